// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: accepts the PAL configuration bitstream as WORD_W-bit words over a
// valid/ready handshake and shifts it LSB-first into the PAL config chain on
// cfg_data/cfg_clk. After the last bit and a short settle time it raises cfg_en.
module pal_cfg_loader #(
  parameter int NUM_INPUTS        = 8,
  parameter int NUM_INTERM_STAGES = 13,
  parameter int NUM_OUTPUTS       = 4,
  parameter int WORD_W            = 8,
  parameter int CLK_DIV           = 2,
  parameter int SETTLE            = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_clk,
  output logic              cfg_data,
  output logic              cfg_en,
  output logic              busy,
  output logic              done
);

  // Chain length; the source supplies ceil(BITSTREAM_LEN/WORD_W) words, and only the
  // low BITSTREAM_LEN mod WORD_W bits of the final word reach the chain.
  localparam int BITSTREAM_LEN = 2*NUM_INPUTS*NUM_INTERM_STAGES + NUM_INTERM_STAGES*NUM_OUTPUTS;
  localparam int BIT_W = $clog2(BITSTREAM_LEN+1);
  localparam int DIV_W = $clog2(CLK_DIV+1);
  localparam int WIB_W = $clog2(WORD_W+1);
  localparam int SET_W = $clog2(SETTLE+1);

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(BITSTREAM_LEN-1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV-1);
  localparam logic [WIB_W-1:0] WORD_LAST = WIB_W'(WORD_W-1);
  localparam logic [SET_W-1:0] SET_LAST  = SET_W'(SETTLE-1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    SETUP  = 3'd2,
    HIGH   = 3'd3,
    SETTLE_ST = 3'd4,
    ACTIVE = 3'd5
  } state_t;

  state_t            state_reg, state_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [DIV_W-1:0]  div_cnt_reg, div_cnt_next;
  logic [WIB_W-1:0]  wib_reg, wib_next;        // bits of current word already shifted
  logic [SET_W-1:0]  set_cnt_reg, set_cnt_next;
  logic [WORD_W-1:0] shift_reg, shift_next;
  logic              cfg_clk_reg, cfg_clk_next;
  logic              cfg_data_reg, cfg_data_next;
  logic              cfg_en_reg, cfg_en_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              word_ready_reg, word_ready_next;

  // State and registered-output update; reset aborts any load in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      div_cnt_reg    <= '0;
      wib_reg        <= '0;
      set_cnt_reg    <= '0;
      shift_reg      <= '0;
      cfg_clk_reg    <= 1'b0;
      cfg_data_reg   <= 1'b0;
      cfg_en_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      word_ready_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      div_cnt_reg    <= div_cnt_next;
      wib_reg        <= wib_next;
      set_cnt_reg    <= set_cnt_next;
      shift_reg      <= shift_next;
      cfg_clk_reg    <= cfg_clk_next;
      cfg_data_reg   <= cfg_data_next;
      cfg_en_reg     <= cfg_en_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      word_ready_reg <= word_ready_next;
    end
  end

  // Next-state and next-output logic; cfg_data only moves while cfg_clk is (or goes) low.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    div_cnt_next  = div_cnt_reg;
    wib_next      = wib_reg;
    set_cnt_next  = set_cnt_reg;
    shift_next    = shift_reg;
    cfg_clk_next  = cfg_clk_reg;
    cfg_data_next = cfg_data_reg;
    cfg_en_next   = cfg_en_reg;
    done_next     = 1'b0;

    case (state_reg)
      IDLE, ACTIVE: begin
        if (start) begin
          state_next   = FETCH;
          cfg_en_next  = 1'b0;
          cfg_clk_next = 1'b0;
          bit_cnt_next = '0;
          div_cnt_next = '0;
          wib_next     = '0;
          set_cnt_next = '0;
        end
      end
      FETCH: begin
        // Stalls here indefinitely with cfg_clk low until the source has a word.
        if (word_valid && word_ready_reg) begin
          shift_next    = word_data;
          cfg_data_next = word_data[0];
          wib_next      = '0;
          div_cnt_next  = '0;
          state_next    = SETUP;
        end
      end
      SETUP: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          cfg_clk_next = 1'b1;
          state_next   = HIGH;
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      HIGH: begin
        if (div_cnt_reg == DIV_LAST) begin
          div_cnt_next = '0;
          cfg_clk_next = 1'b0;
          bit_cnt_next = bit_cnt_reg + 1'b1;
          wib_next     = wib_reg + 1'b1;
          shift_next   = shift_reg >> 1;
          if (bit_cnt_reg == LAST_BIT) begin
            cfg_data_next = 1'b0;
            set_cnt_next  = '0;
            state_next    = SETTLE_ST;
          end else if (wib_reg == WORD_LAST) begin
            state_next = FETCH;
          end else begin
            cfg_data_next = shift_reg[1];
            state_next    = SETUP;
          end
        end else begin
          div_cnt_next = div_cnt_reg + 1'b1;
        end
      end
      SETTLE_ST: begin
        if (set_cnt_reg == SET_LAST) begin
          cfg_en_next = 1'b1;
          done_next   = 1'b1;
          state_next  = ACTIVE;
        end else begin
          set_cnt_next = set_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    word_ready_next = (state_next == FETCH);
    busy_next       = (state_next == FETCH) || (state_next == SETUP) ||
                      (state_next == HIGH)  || (state_next == SETTLE_ST);
  end

  assign word_ready = word_ready_reg;
  assign cfg_clk    = cfg_clk_reg;
  assign cfg_data   = cfg_data_reg;
  assign cfg_en     = cfg_en_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_pal_cfg_loader.sv
// tb_pal_cfg_loader: directed loads of the PAL config loader with CLK_DIV=1, SETTLE=4;
// captures cfg_data at every cfg_clk rise and compares against the words fed in.
module tb_pal_cfg_loader;
  localparam int LEN = 260;
  localparam int NW  = 33;
  localparam int WW  = 8;

  logic       clk = 1'b0;
  logic       rst, start, word_valid, word_ready;
  logic [7:0] word_data;
  logic       cfg_clk, cfg_data, cfg_en, busy, done;

  always #5 clk = ~clk;

  pal_cfg_loader #(.CLK_DIV(1), .SETTLE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .word_data(word_data),
    .word_valid(word_valid), .word_ready(word_ready), .cfg_clk(cfg_clk),
    .cfg_data(cfg_data), .cfg_en(cfg_en), .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Bus monitor, sampled on the rising clk edge (reads pre-edge values).
  logic mon_clr;
  int   ncyc, en_delay, done_cnt, hs_cnt, rise_cnt, viol;
  logic clk_prev, data_prev, en_prev;
  logic cap [0:LEN+15];

  // Track handshakes, cfg_clk rises, done pulses, cfg_en latency and protocol violations.
  always @(posedge clk) begin
    if (mon_clr) begin
      ncyc <= 0; en_delay <= -1; done_cnt <= 0; hs_cnt <= 0; rise_cnt <= 0; viol <= 0;
      clk_prev <= cfg_clk; data_prev <= cfg_data; en_prev <= cfg_en;
    end else begin
      ncyc <= start ? 0 : ncyc + 1;
      if (cfg_en && !en_prev) en_delay <= ncyc;
      en_prev <= cfg_en;
      if (done) done_cnt <= done_cnt + 1;
      if (word_valid && word_ready) hs_cnt <= hs_cnt + 1;
      if (cfg_clk && !clk_prev) begin
        if (rise_cnt < LEN + 16) cap[rise_cnt] <= cfg_data;
        rise_cnt <= rise_cnt + 1;
      end
      if (cfg_clk && (cfg_data !== data_prev)) viol <= viol + 1;
      if (word_ready && cfg_clk) viol <= viol + 1;
      clk_prev  <= cfg_clk;
      data_prev <= cfg_data;
    end
  end

  logic [7:0] words [0:NW-1];

  task automatic fill(input int seed);
    for (int i = 0; i < NW; i++) words[i] = 8'((i * 29 + seed * 71 + 3) ^ (i << 4));
  endtask

  function automatic int stream_err();
    int e = 0;
    for (int i = 0; i < LEN; i++) begin
      logic [7:0] w;
      w = words[i / WW];
      if (cap[i] !== w[i % WW]) e++;
    end
    return e;
  endfunction

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feed words 0..nwords-1; valid held low for 10 cycles before words s0/s1/s2.
  task automatic feed(input int nwords, input int s0, input int s1, input int s2);
    for (int w = 0; w < nwords; w++) begin
      logic ok;
      ok = 1'b0;
      if (w == s0 || w == s1 || w == s2) begin
        word_valid = 1'b0;
        repeat (10) @(negedge clk);
      end
      word_data  = words[w];
      word_valid = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
        if (word_ready) ok = 1'b1;
        @(negedge clk);
      end
      if (!ok) begin
        chk($sformatf("feed_hs_w%0d", w), int'(ok), 1);
        break;
      end
    end
    word_valid = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    for (int t = 0; t < 3000; t++) begin
      if (cfg_en) break;
      @(negedge clk);
    end
    chk(tag, int'(cfg_en), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = '0; mon_clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", int'({cfg_clk, cfg_data, cfg_en, busy, done, word_ready}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Load 1: valid always high, exact timing to cfg_en.
    fill(1);
    word_data = words[0];
    word_valid = 1'b1;
    clear_mon();
    pulse_start();
    chk("l1_busy", int'(busy), 1);
    chk("l1_ready", int'(word_ready), 1);
    feed(NW, -1, -1, -1);
    wait_en("l1_en");
    chk("l1_rises", rise_cnt, LEN);
    chk("l1_hs", hs_cnt, NW);
    chk("l1_en_delay", en_delay, LEN * 2 + NW + 4);
    chk("l1_done", done_cnt, 1);
    chk("l1_stream", stream_err(), 0);
    chk("l1_viol", viol, 0);
    chk("l1_busy_end", int'(busy), 0);
    $display("load1 rises=%0d hs=%0d en_delay=%0d", rise_cnt, hs_cnt, en_delay);

    // Load 2: reload from ACTIVE, stalls before words 0/5/32, truncated last word 0xF5.
    fill(2);
    words[NW-1] = 8'hF5;
    clear_mon();
    pulse_start();
    chk("l2_en_cleared", int'(cfg_en), 0);
    feed(NW, 0, 5, 32);
    wait_en("l2_en");
    chk("l2_rises", rise_cnt, LEN);
    chk("l2_hs", hs_cnt, NW);
    chk("l2_stream", stream_err(), 0);
    chk("l2_last4", int'({cap[259], cap[258], cap[257], cap[256]}), 5);
    chk("l2_viol", viol, 0);
    chk("l2_done", done_cnt, 1);
    $display("load2 rises=%0d hs=%0d viol=%0d", rise_cnt, hs_cnt, viol);

    // Load 3: start pulses mid-load are ignored.
    fill(3);
    clear_mon();
    pulse_start();
    fork
      feed(NW, -1, -1, -1);
      begin
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (51) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    wait_en("l3_en");
    chk("l3_rises", rise_cnt, LEN);
    chk("l3_hs", hs_cnt, NW);
    chk("l3_stream", stream_err(), 0);
    chk("l3_done", done_cnt, 1);
    $display("load3 rises=%0d hs=%0d done=%0d", rise_cnt, hs_cnt, done_cnt);

    // Load 4: asynchronous reset while shifting word 12 with cfg_clk high.
    fill(4);
    clear_mon();
    pulse_start();
    feed(13, -1, -1, -1);
    for (int t = 0; t < 50; t++) begin
      if (cfg_clk) break;
      @(negedge clk);
    end
    chk("l4_in_high", int'(cfg_clk), 1);
    #2 rst = 1'b1;
    #1 chk("l4_rst_outs", int'({cfg_clk, cfg_data, cfg_en, busy, word_ready}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("l4_en_low", int'(cfg_en), 0);
    chk("l4_busy_low", int'(busy), 0);
    $display("load4 aborted by reset, en=%0d busy=%0d", cfg_en, busy);

    // Load 5: clean load after the aborted one.
    fill(5);
    clear_mon();
    pulse_start();
    chk("l5_en_before", int'(cfg_en), 0);
    feed(NW, -1, -1, -1);
    wait_en("l5_en");
    chk("l5_rises", rise_cnt, LEN);
    chk("l5_stream", stream_err(), 0);
    chk("l5_en_delay", en_delay, LEN * 2 + NW + 4);
    $display("load5 rises=%0d en_delay=%0d", rise_cnt, en_delay);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
